// File: rtl/mk_top.sv
// mk_top: multi-cycle, non-pipelined RV32I core. Instruction fetches and LW/SW
// share one get-style request port and one put-style response port.
module mk_top (
    input  logic        CLK,
    input  logic        RST,
    output logic [64:0] obtain_rq_get,
    output logic        RDY_obtain_rq_get,
    input  logic        EN_obtain_rq_get,
    input  logic [31:0] send_rs_put,
    input  logic        EN_send_rs_put,
    output logic        RDY_send_rs_put
);
    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_IWAIT = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_DWAIT = 3'd4;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        store_q, store_d;
    logic [31:0] rf_q [32];

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_res, pc_plus4;
    logic [4:0]  shamt;
    logic        alu_ok, br_taken;
    logic        rf_we;
    logic [31:0] rf_wdata;

    always_comb begin
        opcode  = instr_q[6:0];
        rd      = instr_q[11:7];
        funct3  = instr_q[14:12];
        rs1     = instr_q[19:15];
        rs2     = instr_q[24:20];
        funct7  = instr_q[31:25];
        rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
        rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];
        imm_i   = {{20{instr_q[31]}}, instr_q[31:20]};
        imm_s   = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
        imm_b   = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
        imm_u   = {instr_q[31:12], 12'h000};
        imm_j   = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
        pc_plus4 = pc_q + 32'd4;
    end

    // instr_q[30] selects SUB only for register ops, SRA/SRAI for both forms
    always_comb begin
        alu_b = (opcode == OP_REG) ? rs2_val : imm_i;
        shamt = alu_b[4:0];
        case (funct3)
            3'd0:    alu_res = (opcode == OP_REG && instr_q[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'd1:    alu_res = rs1_val << shamt;
            3'd2:    alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'd3:    alu_res = {31'd0, rs1_val < alu_b};
            3'd4:    alu_res = rs1_val ^ alu_b;
            3'd5:    alu_res = instr_q[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'd6:    alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
        if (opcode == OP_REG)
            alu_ok = (funct7 == 7'h00) ||
                     (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
        else if (funct3 == 3'd1)
            alu_ok = (funct7 == 7'h00);
        else if (funct3 == 3'd5)
            alu_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
        else
            alu_ok = 1'b1;
        case (funct3)
            3'd0:    br_taken = (rs1_val == rs2_val);
            3'd1:    br_taken = (rs1_val != rs2_val);
            3'd4:    br_taken = $signed(rs1_val) <  $signed(rs2_val);
            3'd5:    br_taken = $signed(rs1_val) >= $signed(rs2_val);
            3'd6:    br_taken = rs1_val <  rs2_val;
            3'd7:    br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        store_d  = store_q;
        rf_we    = 1'b0;
        rf_wdata = alu_res;
        case (state_q)
            ST_FETCH: if (EN_obtain_rq_get) state_d = ST_IWAIT;
            ST_IWAIT: if (EN_send_rs_put) begin
                instr_d = send_rs_put;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_plus4;
                case (opcode)
                    OP_LUI: begin
                        rf_we = 1'b1; rf_wdata = imm_u;
                    end
                    OP_AUIPC: begin
                        rf_we = 1'b1; rf_wdata = pc_q + imm_u;
                    end
                    OP_JAL: begin
                        rf_we = 1'b1; rf_wdata = pc_plus4; pc_d = pc_q + imm_j;
                    end
                    OP_JALR: if (funct3 == 3'd0) begin
                        rf_we = 1'b1; rf_wdata = pc_plus4;
                        pc_d = (rs1_val + imm_i) & ~32'd1;
                    end
                    OP_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
                    OP_IMM, OP_REG: rf_we = alu_ok;
                    OP_LOAD: if (funct3 == 3'd2) begin
                        addr_d = rs1_val + imm_i; store_d = 1'b0; wdata_d = '0;
                        pc_d = pc_q; state_d = ST_MEM;
                    end
                    OP_STORE: if (funct3 == 3'd2) begin
                        addr_d = rs1_val + imm_s; store_d = 1'b1; wdata_d = rs2_val;
                        pc_d = pc_q; state_d = ST_MEM;
                    end
                    default: ;
                endcase
            end
            ST_MEM: if (EN_obtain_rq_get) state_d = ST_DWAIT;
            ST_DWAIT: if (EN_send_rs_put) begin
                rf_we    = !store_q;
                rf_wdata = send_rs_put;
                pc_d     = pc_plus4;
                state_d  = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Outputs decode registered state only; RST masks them while held
    always_comb begin
        RDY_obtain_rq_get = !RST && (state_q == ST_FETCH || state_q == ST_MEM);
        RDY_send_rs_put   = !RST && (state_q == ST_IWAIT || state_q == ST_DWAIT);
        obtain_rq_get     = '0;
        if (!RST && state_q == ST_FETCH)
            obtain_rq_get = {pc_q, 1'b0, 32'h0};
        else if (!RST && state_q == ST_MEM)
            obtain_rq_get = {addr_q, store_q, wdata_q};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            store_q <= store_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && rf_we && rd != 5'd0)
            rf_q[rd] <= rf_wdata;
    end
endmodule

// File: tb/tb_mk_top.sv
// Bench for mk_top: memory agent with scoreboard against an instruction-level
// RV32I reference model; directed programs plus randomized programs.
`timescale 1ns/1ps
module tb_mk_top;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [64:0] obtain_rq_get;
    logic        RDY_obtain_rq_get;
    logic        EN_obtain_rq_get;
    logic [31:0] send_rs_put;
    logic        EN_send_rs_put;
    logic        RDY_send_rs_put;

    always #5 CLK = ~CLK;

    mk_top dut (
        .CLK(CLK), .RST(RST),
        .obtain_rq_get(obtain_rq_get), .RDY_obtain_rq_get(RDY_obtain_rq_get),
        .EN_obtain_rq_get(EN_obtain_rq_get),
        .send_rs_put(send_rs_put), .EN_send_rs_put(EN_send_rs_put),
        .RDY_send_rs_put(RDY_send_rs_put)
    );

    // gap: -1 data access, else expected cycles since previous fetch acceptance
    typedef struct { logic [64:0] req; int gap; } exp_t;
    exp_t        exp_q[$];
    logic [64:0] wr_log[$];
    logic [31:0] fetch_log[$];
    logic [31:0] img[1024], tmem[1024], smem[1024], sreg[32], spc;
    int          s_gap;
    int          n_tests = 0, n_fail = 0;
    int          req_dly = 0, rsp_dly = 0;
    bit          dly_rand = 0, spur = 0, gap_chk = 1;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(logic [31:0] imm, logic [4:0] rd, logic [6:0] op);
        return {imm[19:0], rd, op};
    endfunction
    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] alu(logic [2:0] f3, bit alt, logic [31:0] a, logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // One architectural instruction; queues every memory request it causes
    task automatic iss_step();
        logic [31:0] in, a, b, ii, is_, ib, iu, ij, res, nxt, ea;
        logic [2:0] f3;
        logic [6:0] f7;
        bit wr, mem, take;
        in = smem[spc[11:2]];
        exp_q.push_back('{{spc, 1'b0, 32'h0}, s_gap});
        f3 = in[14:12]; f7 = in[31:25];
        a = sreg[in[19:15]]; b = sreg[in[24:20]];
        ii  = {{20{in[31]}}, in[31:20]};
        is_ = {{20{in[31]}}, in[31:25], in[11:7]};
        ib  = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
        iu  = {in[31:12], 12'h0};
        ij  = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
        nxt = spc + 4; wr = 0; mem = 0; res = 0;
        case (in[6:0])
            7'h37: begin wr = 1; res = iu; end
            7'h17: begin wr = 1; res = spc + iu; end
            7'h6f: begin wr = 1; res = spc + 4; nxt = spc + ij; end
            7'h67: if (f3 == 0) begin wr = 1; res = spc + 4; nxt = (a + ii) & ~32'd1; end
            7'h63: begin
                case (f3)
                    3'd0: take = (a == b);
                    3'd1: take = (a != b);
                    3'd4: take = $signed(a) < $signed(b);
                    3'd5: take = $signed(a) >= $signed(b);
                    3'd6: take = a < b;
                    3'd7: take = a >= b;
                    default: take = 0;
                endcase
                if (take) nxt = spc + ib;
            end
            7'h13: begin
                wr = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1;
                res = alu(f3, f3 == 5 && in[30], a, ii);
            end
            7'h33: begin
                wr = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                res = alu(f3, in[30], a, b);
            end
            7'h03: if (f3 == 2) begin
                mem = 1; ea = a + ii;
                exp_q.push_back('{{ea, 1'b0, 32'h0}, -1});
                wr = 1; res = smem[ea[11:2]];
            end
            7'h23: if (f3 == 2) begin
                mem = 1; ea = a + is_;
                exp_q.push_back('{{ea, 1'b1, b}, -1});
                smem[ea[11:2]] = b;
            end
            default: ;
        endcase
        if (wr && in[11:7] != 0) sreg[in[11:7]] = res;
        spc = nxt;
        s_gap = mem ? 5 : 3;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [31:0] r, off;
        int k;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); f3 = 3'($urandom);
        r = $urandom; k = int'($urandom_range(19, 0));
        off = $urandom_range(127, 0) * 2 - 128;
        case (k)
            0: return enc_u(r, rd, 7'h37);
            1: return enc_u(r, rd, 7'h17);
            2: return enc_j(off, rd);
            3: return enc_i(r[11:0], rs1, 3'd0, rd, 7'h67);
            4, 5: return enc_b(off, rs2, rs1, f3);
            6, 7, 8, 9: begin
                if (f3 == 1 || f3 == 5)
                    return enc_i({($urandom_range(3, 0) == 0) ? 7'h20 : 7'h00, r[4:0]}, rs1, f3, rd, 7'h13);
                return enc_i(r[11:0], rs1, f3, rd, 7'h13);
            end
            10, 11, 12: return enc_r(r[20] ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
            13, 14: return enc_i(r[11:0], rs1, 3'd2, rd, 7'h03);
            15, 16: return enc_s(r[11:0], rs2, rs1, 3'd2);
            17: return r;
            18: return enc_i(r[11:0], rs1, f3, rd, 7'h03);
            default: return enc_s(r[11:0], rs2, rs1, f3);
        endcase
    endfunction

    // Memory agent: drives EN inputs at negedge, checks every accepted request
    initial begin : agent
        bit pend, armed, prev_wait;
        int qwait, rwait, cyc, last_fetch;
        logic [64:0] prev_req, rq;
        logic [31:0] rdata;
        exp_t e;
        pend = 0; armed = 0; prev_wait = 0; qwait = 0; rwait = 0; cyc = 0; last_fetch = 0;
        prev_req = '0; rdata = '0;
        EN_obtain_rq_get = 0; EN_send_rs_put = 0; send_rs_put = '0;
        forever begin
            @(negedge CLK);
            cyc++;
            EN_obtain_rq_get = 0; EN_send_rs_put = 0;
            if (RST) begin
                check("rst_rdy_req", RDY_obtain_rq_get, 0);
                check("rst_rdy_rsp", RDY_send_rs_put, 0);
                check("rst_req", obtain_rq_get, 0);
                pend = 0; armed = 0; prev_wait = 0; last_fetch = cyc;
                continue;
            end
            if (prev_wait) check("req_stable", {RDY_obtain_rq_get, obtain_rq_get}, {1'b1, prev_req});
            prev_wait = 0;
            if (pend) check("outstanding_rdy", {RDY_obtain_rq_get, RDY_send_rs_put}, 2'b01);
            if (RDY_obtain_rq_get && !pend) begin
                if (!armed) begin
                    qwait = dly_rand ? int'($urandom_range(req_dly, 0)) : req_dly;
                    armed = 1;
                end
                if (qwait > 0) begin
                    qwait--; prev_wait = 1; prev_req = obtain_rq_get;
                    if (spur && $urandom_range(2, 0) == 0) begin
                        EN_send_rs_put = 1; send_rs_put = $urandom;
                    end
                end else begin
                    EN_obtain_rq_get = 1; armed = 0; pend = 1;
                    rq = obtain_rq_get;
                    rwait = dly_rand ? int'($urandom_range(rsp_dly, 0)) : rsp_dly;
                    if (rq[32]) begin
                        tmem[rq[44:35]] = rq[31:0];
                        wr_log.push_back(rq);
                    end
                    rdata = tmem[rq[44:35]];
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("request", rq, e.req);
                        if (e.gap >= 0) begin
                            if (gap_chk && e.gap > 0) check("fetch_spacing", cyc - last_fetch, e.gap);
                            last_fetch = cyc;
                            fetch_log.push_back(rq[64:33]);
                        end
                    end
                end
            end else if (pend && RDY_send_rs_put) begin
                if (rwait > 0) rwait--;
                else begin
                    EN_send_rs_put = 1; send_rs_put = rdata; pend = 0;
                end
            end else if (!pend && spur && $urandom_range(2, 0) == 0) begin
                EN_send_rs_put = 1; send_rs_put = $urandom;
            end
        end
    end

    task automatic run_prog(input int steps, input bit chk_rst);
        @(posedge CLK); #1 RST = 1;
        for (int i = 0; i < 1024; i++) begin tmem[i] = img[i]; smem[i] = img[i]; end
        for (int i = 0; i < 32; i++) sreg[i] = '0;
        exp_q.delete(); wr_log.delete(); fetch_log.delete();
        spc = '0; s_gap = 1;
        gap_chk = (req_dly == 0 && rsp_dly == 0);
        for (int i = 0; i < steps; i++) iss_step();
        repeat (2) @(posedge CLK);
        #1 RST = 0;
        if (chk_rst) begin
            @(negedge CLK);
            check("first_fetch", {RDY_obtain_rq_get, obtain_rq_get}, {1'b1, 65'h0});
            @(negedge CLK);
            check("first_wait", RDY_send_rs_put, 1);
        end
        for (int c = 0; c < steps * 40 + 100 && exp_q.size() > 0; c++) @(posedge CLK);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 1024; i++) img[i] = 32'h00000013;
    endtask

    task automatic check_fetches(input logic [31:0] seq[$]);
        check("fetch_count", fetch_log.size(), seq.size());
        for (int i = 0; i < seq.size() && i < fetch_log.size(); i++)
            check("fetch_addr", fetch_log[i], seq[i]);
    endtask

    task automatic load_roundtrip();
        clear_img();
        img[0] = enc_u(32'hDEADC, 5'd1, 7'h37);
        img[1] = enc_i(12'hEEF, 5'd1, 3'd0, 5'd1, 7'h13);
        img[2] = enc_s(12'h040, 5'd1, 5'd0, 3'd2);
        img[3] = enc_i(12'h040, 5'd0, 3'd2, 5'd3, 7'h03);
        img[4] = enc_s(12'h044, 5'd3, 5'd0, 3'd2);
    endtask

    initial begin : main
        // MMIO store
        clear_img();
        img[0] = enc_u(32'h10012, 5'd2, 7'h37);
        img[1] = enc_i(12'h05A, 5'd0, 3'd0, 5'd1, 7'h13);
        img[2] = enc_s(12'd12, 5'd1, 5'd2, 3'd2);
        run_prog(3, 1);
        check("mmio_nwr", wr_log.size(), 1);
        if (wr_log.size() > 0) check("mmio_wr", wr_log[0], {32'h1001200c, 1'b1, 32'h0000005A});

        load_roundtrip();
        run_prog(5, 0);
        check("rt_nwr", wr_log.size(), 2);
        if (wr_log.size() > 1) check("rt_wr", wr_log[1], {32'h44, 1'b1, 32'hDEADBEEF});

        // branches
        clear_img();
        img[0]  = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13);
        img[1]  = enc_i(12'h001, 5'd0, 3'd0, 5'd2, 7'h13);
        img[2]  = enc_b(32'h40, 5'd2, 5'd1, 3'd6);
        img[4]  = enc_b(32'h8, 5'd0, 5'd0, 3'd0);
        img[6]  = enc_b(32'h20, 5'd2, 5'd1, 3'd4);
        img[14] = enc_s(12'h0, 5'd1, 5'd0, 3'd2);
        run_prog(7, 0);
        check_fetches('{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h18, 32'h38});
        if (wr_log.size() > 0) check("br_wr", wr_log[0], {32'h0, 1'b1, 32'hFFFFFFFF});

        // jumps and x0
        clear_img();
        img[1] = enc_j(32'h20, 5'd1);
        img[9] = enc_i(12'd3, 5'd1, 3'd0, 5'd0, 7'h67);
        img[2] = enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13);
        img[3] = enc_s(12'h050, 5'd0, 5'd0, 3'd2);
        img[4] = enc_s(12'h054, 5'd1, 5'd0, 3'd2);
        run_prog(6, 0);
        check_fetches('{32'h0, 32'h4, 32'h24, 32'hA, 32'hE, 32'h12});
        check("jmp_nwr", wr_log.size(), 2);
        if (wr_log.size() > 1) begin
            check("x0_wr", wr_log[0], {32'h50, 1'b1, 32'h0});
            check("link_wr", wr_log[1], {32'h54, 1'b1, 32'h8});
        end

        // stalls with spurious responses
        req_dly = 5; rsp_dly = 3; dly_rand = 0; spur = 1;
        load_roundtrip();
        run_prog(5, 0);
        check("stall_nwr", wr_log.size(), 2);
        if (wr_log.size() > 1) check("stall_wr", wr_log[1], {32'h44, 1'b1, 32'hDEADBEEF});

        // random programs: register prologue then random instructions
        for (int run = 0; run < 3; run++) begin
            req_dly = run * 3; rsp_dly = run * 3; dly_rand = 1; spur = 1;
            for (int r = 1; r < 32; r++) begin
                img[2*r-2] = enc_u($urandom, 5'(r), 7'h37);
                img[2*r-1] = enc_i(12'($urandom), 5'(r), 3'd0, 5'(r), 7'h13);
            end
            for (int i = 62; i < 1024; i++) img[i] = rnd_instr();
            run_prog(400, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
